// File: rtl/riscv_bus_pkg.sv
// Shared definitions for the dBus responder: lane size masks, FSM states
// and the lane-shift helper used for byte-enable generation.
package riscv_bus_pkg;

  localparam logic [3:0] SIZE_MASK_BYTE = 4'b0001;
  localparam logic [3:0] SIZE_MASK_HALF = 4'b0011;
  localparam logic [3:0] SIZE_MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } resp_state_t;

  // Bits shifted past lane 3 only occur for misaligned accesses, which never write.
  function automatic logic [3:0] lane_mask(input logic [3:0] size, input logic [1:0] offset);
    logic [6:0] wide;
    wide = {3'b000, size} << offset;
    return wide[3:0];
  endfunction

endpackage

// File: rtl/dbus_mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dbus_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // A write cycle leaves rdata untouched; only pure reads refresh it.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dbus_mem_responder.sv
// dBus target backed by on-chip RAM: accepts load/store commands, inserts
// WAIT_STATES cycles, and returns a one-cycle response with error flag.
module dbus_mem_responder
  import riscv_bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic [31:0] dBus_cmd_payload_addr,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [3:0]  dBus_cmd_payload_size,
  input  logic        dBus_cmd_payload_wr,
  output logic [31:0] dBus_rsp_data,
  output logic        dBus_rsp_valid,
  output logic        dBus_rsp_error
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  resp_state_t state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic        accept, exec;

  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_size;
  logic        cmd_wr;

  logic [31:0] x_addr, x_data, x_off, x_wdata;
  logic [3:0]  x_size, x_mask;
  logic        x_wr, x_err;

  logic        rsp_valid_q, rsp_error_q, rsp_load_q;
  logic [1:0]  rsp_shift_q;
  logic [3:0]  rsp_size_q;
  logic [31:0] ram_rdata, lane_word, width_mask;

  assign accept = dBus_cmd_valid && dBus_cmd_ready;

  always_comb begin
    next_state     = state;
    next_cnt       = cnt;
    dBus_cmd_ready = 1'b0;
    exec           = 1'b0;
    case (state)
      ST_IDLE, ST_RESP: begin
        dBus_cmd_ready = 1'b1;
        if (dBus_cmd_valid) begin
          if (WAIT_STATES == 0) begin
            next_state = ST_RESP;
            exec       = 1'b1;
          end else begin
            next_state = ST_WAIT;
            next_cnt   = WAIT_INIT;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          next_state = ST_RESP;
          exec       = 1'b1;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // With no wait states the access executes on the accepting edge, so the
  // live command is used; otherwise the latched copy from the accept edge.
  always_comb begin
    x_addr = (state == ST_WAIT) ? cmd_addr : dBus_cmd_payload_addr;
    x_data = (state == ST_WAIT) ? cmd_data : dBus_cmd_payload_data;
    x_size = (state == ST_WAIT) ? cmd_size : dBus_cmd_payload_size;
    x_wr   = (state == ST_WAIT) ? cmd_wr   : dBus_cmd_payload_wr;
    x_off  = x_addr - BASE_ADDR;
    x_mask = lane_mask(x_size, x_addr[1:0]);
    x_wdata = x_data << {x_addr[1:0], 3'b000};
    x_err  = ((x_size != SIZE_MASK_BYTE) && (x_size != SIZE_MASK_HALF) && (x_size != SIZE_MASK_WORD))
          || ((x_size == SIZE_MASK_HALF) && x_addr[0])
          || ((x_size == SIZE_MASK_WORD) && (x_addr[1:0] != 2'b00))
          || ({1'b0, x_off} >= SPAN);
  end

  dbus_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_array (
    .clk  (clk),
    .en   (exec && !x_err && !rst),
    .we   (x_wr ? x_mask : 4'b0000),
    .addr (x_off[AW+1:2]),
    .wdata(x_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_shift_q <= 2'b00;
      rsp_size_q  <= 4'b0000;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      rsp_valid_q <= exec;
      rsp_error_q <= exec && x_err;
      rsp_load_q  <= exec && !x_err && !x_wr;
      rsp_shift_q <= x_addr[1:0];
      rsp_size_q  <= x_size;
      if (accept) begin
        cmd_addr <= dBus_cmd_payload_addr;
        cmd_data <= dBus_cmd_payload_data;
        cmd_size <= dBus_cmd_payload_size;
        cmd_wr   <= dBus_cmd_payload_wr;
      end
    end
  end

  // Load data is aligned from the registered RAM word; everything else reads zero.
  assign lane_word  = ram_rdata >> {rsp_shift_q, 3'b000};
  assign width_mask = {{8{rsp_size_q[3]}}, {8{rsp_size_q[2]}}, {8{rsp_size_q[1]}}, {8{rsp_size_q[0]}}};

  assign dBus_rsp_valid = rsp_valid_q;
  assign dBus_rsp_error = rsp_error_q;
  assign dBus_rsp_data  = rsp_load_q ? (lane_word & width_mask) : 32'h0;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Directed bench: a zero-wait-state instance driven from a vector table and
// a three-wait-state instance exercising latency, throughput and reset.
module tb_dbus_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic        a_rst, a_valid, a_ready, a_wr, a_rsp_valid, a_rsp_error;
  logic [31:0] a_addr, a_data, a_rsp_data;
  logic [3:0]  a_size;

  logic        b_rst, b_valid, b_ready, b_wr, b_rsp_valid, b_rsp_error;
  logic [31:0] b_addr, b_data, b_rsp_data;
  logic [3:0]  b_size;

  dbus_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_a (
    .clk(clk), .rst(a_rst),
    .dBus_cmd_valid(a_valid), .dBus_cmd_ready(a_ready),
    .dBus_cmd_payload_addr(a_addr), .dBus_cmd_payload_data(a_data),
    .dBus_cmd_payload_size(a_size), .dBus_cmd_payload_wr(a_wr),
    .dBus_rsp_data(a_rsp_data), .dBus_rsp_valid(a_rsp_valid), .dBus_rsp_error(a_rsp_error)
  );

  dbus_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut_b (
    .clk(clk), .rst(b_rst),
    .dBus_cmd_valid(b_valid), .dBus_cmd_ready(b_ready),
    .dBus_cmd_payload_addr(b_addr), .dBus_cmd_payload_data(b_data),
    .dBus_cmd_payload_size(b_size), .dBus_cmd_payload_wr(b_wr),
    .dBus_rsp_data(b_rsp_data), .dBus_rsp_valid(b_rsp_valid), .dBus_rsp_error(b_rsp_error)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  size;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(logic wr, logic [31:0] addr, logic [31:0] data,
                              logic [3:0] size, logic err, logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.size = size; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit to_b, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] size);
    if (to_b) begin
      b_valid = 1'b1; b_wr = wr; b_addr = addr; b_data = data; b_size = size;
    end else begin
      a_valid = 1'b1; a_wr = wr; a_addr = addr; a_data = data; a_size = size;
    end
  endtask

  task automatic checkA(input string tag, input logic v, input logic e, input logic [31:0] d);
    checkOutput({tag, ".ready"}, 32'(a_ready), 32'd1);
    checkOutput({tag, ".valid"}, 32'(a_rsp_valid), 32'(v));
    checkOutput({tag, ".error"}, 32'(a_rsp_error), 32'(e));
    checkOutput({tag, ".data"}, a_rsp_data, d);
  endtask

  task automatic checkB(input string tag, input logic r, input logic v, input logic e,
                        input logic [31:0] d);
    checkOutput({tag, ".ready"}, 32'(b_ready), 32'(r));
    checkOutput({tag, ".valid"}, 32'(b_rsp_valid), 32'(v));
    checkOutput({tag, ".error"}, 32'(b_rsp_error), 32'(e));
    checkOutput({tag, ".data"}, b_rsp_data, d);
  endtask

  // Called right after issuing a command on B: three stall cycles, then the response cycle.
  task automatic expectB(input string tag, input logic e, input logic [31:0] d);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) b_valid = 1'b0;
      checkB($sformatf("%s.wait%0d", tag, k), 1'b0, 1'b0, 1'b0, 32'h0);
    end
    @(negedge clk);
    checkB({tag, ".resp"}, 1'b1, 1'b1, e, d);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = mk(1, 32'h0000, 32'hCAFEF00D, 4'b1111, 0, 32'h0);
    vecs[1]  = mk(1, 32'h0010, 32'hDEADBEEF, 4'b1111, 0, 32'h0);
    vecs[2]  = mk(0, 32'h0010, 32'h0,        4'b1111, 0, 32'hDEADBEEF);
    vecs[3]  = mk(1, 32'h0010, 32'h11223344, 4'b1111, 0, 32'h0);
    vecs[4]  = mk(1, 32'h0013, 32'h000000AA, 4'b0001, 0, 32'h0);
    vecs[5]  = mk(0, 32'h0010, 32'h0,        4'b1111, 0, 32'hAA223344);
    vecs[6]  = mk(0, 32'h0013, 32'h0,        4'b0001, 0, 32'h000000AA);
    vecs[7]  = mk(0, 32'h0012, 32'h0,        4'b0011, 0, 32'h0000AA22);
    vecs[8]  = mk(0, 32'h0011, 32'h0,        4'b0001, 0, 32'h00000033);
    vecs[9]  = mk(0, 32'h0010, 32'h0,        4'b0011, 0, 32'h00003344);
    vecs[10] = mk(0, 32'h0006, 32'h0,        4'b1111, 1, 32'h0);
    vecs[11] = mk(1, 32'h0001, 32'h0000BEEF, 4'b0011, 1, 32'h0);
    vecs[12] = mk(0, 32'h0000, 32'h0,        4'b1111, 0, 32'hCAFEF00D);
    vecs[13] = mk(0, 32'h1000, 32'h0,        4'b1111, 1, 32'h0);
    vecs[14] = mk(0, 32'h0010, 32'h0,        4'b0111, 1, 32'h0);
    vecs[15] = mk(1, 32'h0010, 32'hFFFFFFFF, 4'b0111, 1, 32'h0);
    vecs[16] = mk(0, 32'h0010, 32'h0,        4'b1111, 0, 32'hAA223344);
    vecs[17] = mk(1, 32'h0012, 32'hFFFF1234, 4'b0011, 0, 32'h0);
    vecs[18] = mk(0, 32'h0010, 32'h0,        4'b1111, 0, 32'h12343344);
    vecs[19] = mk(0, 32'h0012, 32'hFFFFFFFF, 4'b0001, 0, 32'h00000034);
    vecs[20] = mk(1, 32'h0FFC, 32'hA5A55A5A, 4'b1111, 0, 32'h0);
    vecs[21] = mk(0, 32'h0FFC, 32'h0,        4'b1111, 0, 32'hA5A55A5A);
    vecs[22] = mk(1, 32'h1003, 32'h00000077, 4'b0001, 1, 32'h0);
    vecs[23] = mk(0, 32'h0003, 32'h0,        4'b0011, 1, 32'h0);
    vecs[24] = mk(0, 32'h0010, 32'h0,        4'b0000, 1, 32'h0);

    a_rst = 1'b1; a_valid = 1'b0; a_wr = 1'b0; a_addr = '0; a_data = '0; a_size = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_wr = 1'b0; b_addr = '0; b_data = '0; b_size = '0;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    checkA("reset_a", 1'b0, 1'b0, 32'h0);
    checkB("reset_b", 1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] table vectors, zero wait states");
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      checkA($sformatf("vec%0d.idle", i), 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].size);
      @(negedge clk);
      a_valid = 1'b0;
      checkA($sformatf("vec%0d.rsp", i), 1'b1, vecs[i].err, vecs[i].rdata);
    end

    $display("[TB] back-to-back store/load hazard");
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h20, 32'hFFFFFF00, 4'b1111);
    @(negedge clk);
    checkA("b2b.store_w", 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h00000055, 4'b0001);
    @(negedge clk);
    checkA("b2b.store_b", 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 4'b0001);
    @(negedge clk);
    checkA("b2b.load_b", 1'b1, 1'b0, 32'h00000055);
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 4'b1111);
    @(negedge clk);
    a_valid = 1'b0;
    checkA("b2b.load_w", 1'b1, 1'b0, 32'hFFFFFF55);
    @(negedge clk);
    checkA("b2b.idle", 1'b0, 1'b0, 32'h0);

    $display("[TB] three wait states: latency and throughput");
    applyStimulus(1'b1, 1'b1, 32'h30, 32'h0BADF00D, 4'b1111);
    expectB("ws3.store", 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'b1111);
    expectB("ws3.load1", 1'b0, 32'h0BADF00D);
    applyStimulus(1'b1, 1'b0, 32'h31, 32'h0, 4'b0001);
    expectB("ws3.load2", 1'b0, 32'h000000F0);
    @(negedge clk);
    checkB("ws3.idle", 1'b1, 1'b0, 1'b0, 32'h0);

    $display("[TB] reset during wait states");
    applyStimulus(1'b1, 1'b1, 32'h30, 32'h12345678, 4'b1111);
    @(negedge clk);
    b_valid = 1'b0;
    checkB("rst.wait1", 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    checkB("rst.after", 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkB($sformatf("rst.quiet%0d", k), 1'b1, 1'b0, 1'b0, 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'b1111);
    expectB("rst.reload", 1'b0, 32'h0BADF00D);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_mem_responder.md
Name: dbus_mem_responder

Overview:
Data-bus responder (target) for the core's dBus initiator port. It accepts load/store commands on the dBus cmd channel and services them from an internal word-addressed, byte-lane-writable RAM, with a configurable number of wait states. It returns read data right-justified, with the upper bits zero-filled, on the rsp channel, and flags range, alignment and encoding errors. It sits between the core and the on-chip data memory, and is used as the data memory in simulation and on FPGA.

Parameters:
DEPTH_WORDS, 1024, RAM depth in 32-bit words; must be a power of 2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.
WAIT_STATES, 0, extra cycles between command acceptance and response; range 0..15.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous reset, active-high.
dBus_cmd_valid  input  1  command valid from the core.
dBus_cmd_ready  output  1  responder can accept a command this cycle.
dBus_cmd_payload_addr  input  32  byte address.
dBus_cmd_payload_data  input  32  store data, right-justified (lane 0).
dBus_cmd_payload_size  input  4  lane mask at lane 0: 4'b0001 byte, 4'b0011 half, 4'b1111 word.
dBus_cmd_payload_wr  input  1  1 = store, 0 = load.
dBus_rsp_data  output  32  load data, right-justified, upper bits zero-filled.
dBus_rsp_valid  output  1  one-cycle response pulse.
dBus_rsp_error  output  1  qualifies rsp_valid; the access failed.

Behaviour:
- Reset values: state=IDLE, dBus_cmd_ready=1, dBus_rsp_valid=0, dBus_rsp_error=0, dBus_rsp_data=0, wait counter=0. RAM contents are not reset.
- FSM states:
  - IDLE: ready=1. On valid&ready, latch addr/data/size/wr; go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else go to RESP.
  - WAIT: ready=0. Decrement the counter; go to RESP when the counter is 0.
  - RESP: rsp_valid=1 for exactly this cycle; ready=1. A new valid command is accepted in the same cycle (back-to-back); otherwise go to IDLE.
- Latency: for a command accepted on edge E, rsp_valid is high in the cycle starting at edge E+WAIT_STATES+1.
- Throughput:
  - WAIT_STATES=0: one command per cycle.
  - Otherwise: one command per WAIT_STATES+1 cycles.
- Responses are in order. There is no rsp backpressure; the response is never delayed or dropped.
- Access execution: the RAM access commits on the edge entering RESP, and rsp outputs are registered on that edge.
- Lane alignment:
  - Effective byte mask = size << addr[1:0].
  - Store data = data << 8*addr[1:0].
  - Load data = word >> 8*addr[1:0], then masked to the access width.
- Store response: rsp_data=0, rsp_error=0.
- Error response: rsp_valid=1, rsp_error=1, rsp_data=0, no RAM write. An access is an error when any of these holds:
  - size is not one of 0001/0011/1111;
  - the half access has addr[0]=1, or the word access has addr[1:0]!=0;
  - addr-BASE_ADDR is at or beyond DEPTH_WORDS*4.
- RAM word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Hazard: a load accepted in RESP of a preceding store to the same word returns the newly stored bytes.
- Reset mid-operation (WAIT or RESP): the latched command is dropped. No write commits if rst is high on the commit edge. No response is issued; next state is IDLE.
- Signals other than valid are ignored when valid=0. A command presented while ready=0 is not accepted and must be held by the initiator.

Decomposition:
- Package riscv_bus_pkg:
  - size mask constants SIZE_MASK_BYTE/HALF/WORD;
  - responder state enum {ST_IDLE, ST_WAIT, ST_RESP};
  - the function computing the lane-shifted byte mask.
- Sub-module dbus_mem_array: a single-port RAM of DEPTH_WORDS x 32 with a 4-bit byte-write enable and synchronous read, instantiated once.
- The FSM, the error check and lane alignment stay in dbus_mem_responder.

Test Plan:
- WAIT_STATES=0, BASE_ADDR=0:
  - store word 0xDEADBEEF to 0x10, then load word 0x10 → rsp_data=0xDEADBEEF, error=0.
  - each rsp_valid comes 1 cycle after its accept; ready stays 1 throughout.
- Byte/half lanes:
  - store byte 0xAA to 0x13 over word 0x11223344 → word reads 0xAA223344.
  - load byte at 0x13 → 0x000000AA.
  - load half at 0x12 → 0x0000AA22.
- Errors:
  - load word at 0x6 → rsp_error=1, data=0.
  - store half at 0x1 → error=1 and the RAM word is unchanged.
  - load at 0x1000 with DEPTH_WORDS=1024 → error=1.
  - size=4'b0111 → error=1.
- WAIT_STATES=3:
  - a load accepted at cycle 0 → ready=0 in cycles 1-3, rsp_valid high only in cycle 4, ready=1 in cycle 4.
  - a second load accepted in cycle 4 → response in cycle 8.
- Back-to-back hazard (WAIT_STATES=0): store 0x55 byte to 0x20 immediately followed by load byte 0x20 → second response data=0x00000055.
- Reset mid-op (WAIT_STATES=3): store to 0x30 accepted, rst asserted in cycle 2 → no rsp_valid; a later load of 0x30 returns the prior value; after rst, ready=1 and rsp outputs are 0.
